word_byte_serializer: RTL and testbench
=======================================

# word_byte_serializer

Sequential stage directly downstream of the word-to-byte split in the cache read datapath. It accepts one 32-bit word (big-endian bit numbering, bits [0:7] = byte 0) with a start byte and length, and emits the selected bytes one per handshake, byte 0 side first. This turns the single-byte tap into a full serial byte stream with valid/ready flow control toward the byte consumer.

## Interface
- No parameters. Word width is fixed at 32 and byte width at 8, matching the existing word/byte datapath.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of the word in flight
- w_valid  in  1  word offer
- w_ready  out  1  word accept (combinational)
- w_data  in  [0:31]  word; byte i = w_data[8i:8i+7]
- w_start  in  [1:0]  first byte index to emit
- w_len  in  [2:0]  requested byte count
- b_valid  out  1  byte offer (registered)
- b_ready  in  1  byte accept
- b_data  out  [0:7]  current byte (registered)
- b_idx  out  [1:0]  byte index of b_data within its word
- b_last  out  1  marks the final byte of the word

## Operation
- States: IDLE, SEND.
- Word handshake occurs when w_valid & w_ready & rst_n.
- w_ready = !flush & (state==IDLE | (b_valid & b_ready & b_last)).
- On accept:
  - Latch w_data.
  - Compute n = min(w_len, 4 - w_start), using 3-bit unsigned arithmetic. Values of w_len from 5 to 7 clip the same way.
  - If n==0: drop the word and stay in (or return to) IDLE. No byte is emitted.
  - Else: go to SEND with b_idx=w_start, b_data = byte w_start, b_valid=1, and b_last=(n==1).
- In SEND, on b_valid & b_ready:
  - If b_last: go to IDLE and clear b_valid, unless a new word is accepted in the same cycle. In that case load the new word as above, with no bubble.
  - Else: increment b_idx, load b_data = byte b_idx+1, and set b_last when the remaining count reaches 1.
- In SEND with b_ready=0: b_data, b_idx and b_last hold, and b_valid stays 1.
- flush=1 has priority over every handshake:
  - Next state is IDLE with b_valid=0.
  - w_ready=0 in the flush cycle, so no word is lost or accepted.
  - A byte handshake that coincides with flush is still counted by the consumer; the serializer simply stops after it.
- Reset (asserted at any time, including mid-word):
  - State goes to IDLE.
  - b_valid=0, b_data=8'h00, b_idx=0, b_last=0.
  - The latched word is cleared.
  - w_ready reads 1 while in IDLE, but no accept occurs while rst_n=0.

## Timing
- Latency: a word accepted at edge N presents its first byte from N+1.
- Throughput: one byte per cycle while b_ready=1. Back-to-back words are gap-free because of the last-byte/accept overlap.
- A word of n bytes with b_ready held at 1 occupies exactly n cycles of b_valid.
- A zero-length word costs one accept cycle and produces no b_valid.
- All outputs except w_ready are registered.
- w_ready depends combinationally on b_ready and flush.
- rst_n is asynchronous on assert. It is deasserted synchronously upstream of this block.

## Test plan
- Full word, no backpressure: w_data=32'hA1B2C3D4, w_start=0, w_len=4, b_ready=1. Required: b_data A1,B2,C3,D4 on cycles N+1..N+4, b_idx 0..3, b_last=1 only with D4, b_valid=0 at N+5.
- Clipping and offset:
  - w_start=2, w_len=4 gives C3,D4 with b_last on D4.
  - w_start=1, w_len=1 gives B2 alone, with b_last=1.
- Backpressure: b_ready pattern 1,0,0,1,1,0,1 across a 4-byte word. Required: b_data/b_idx stable while b_ready=0, all four bytes in order, exactly four handshakes.
- Back-to-back: two words 32'h11223344 and 32'h55667788 (start 0, len 4) with w_valid held and b_ready=1. Required: 8 consecutive b_valid cycles 11..44,55..88, and w_ready=1 only in the accept cycles.
- Zero length: w_len=0 with w_valid=1 for one cycle. Required: w_ready=1, no b_valid asserted, and the next word is accepted the following cycle.
- Abort:
  - flush at the 2nd byte of a 4-byte word: b_valid=0 next cycle, w_ready=0 during the flush cycle, and a new word is accepted cleanly afterward.
  - Same scenario using rst_n low mid-word: all outputs take their reset values immediately.

Source files
------------

// File: rtl/word_byte_serializer.sv
// Serializes one 32-bit word (byte 0 = bits [0:7]) into a valid/ready byte stream,
// emitting bytes w_start .. w_start+n-1 where n = min(w_len, 4 - w_start).
//
//   state | meaning
//   IDLE  | no byte on offer, waiting for a word
//   SEND  | b_data/b_idx/b_last on offer with b_valid=1
module word_byte_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        w_valid,
    output logic        w_ready,
    input  logic [0:31] w_data,
    input  logic [1:0]  w_start,
    input  logic [2:0]  w_len,
    output logic        b_valid,
    input  logic        b_ready,
    output logic [0:7]  b_data,
    output logic [1:0]  b_idx,
    output logic        b_last
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [0:31] word_q, word_d;
    logic [0:7]  b_data_q, b_data_d;
    logic [1:0]  b_idx_q, b_idx_d;
    logic        b_last_q, b_last_d;
    logic        b_valid_q, b_valid_d;
    logic [2:0]  rem_q, rem_d;

    logic        byte_hs;
    logic        word_acc;
    logic [2:0]  avail;
    logic [2:0]  n_take;

    function automatic logic [0:7] pick_byte(input logic [0:31] word, input logic [1:0] idx);
        logic [0:7] sel;
        case (idx)
            2'd0:    sel = word[0:7];
            2'd1:    sel = word[8:15];
            2'd2:    sel = word[16:23];
            default: sel = word[24:31];
        endcase
        return sel;
    endfunction

    // w_len of 5..7 clips to the bytes actually left in the word
    assign avail    = 3'd4 - {1'b0, w_start};
    assign n_take   = (w_len < avail) ? w_len : avail;

    assign byte_hs  = b_valid_q & b_ready;
    assign w_ready  = !flush & ((state_q == IDLE) | (byte_hs & b_last_q));
    assign word_acc = w_valid & w_ready & rst_n;

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        b_data_d  = b_data_q;
        b_idx_d   = b_idx_q;
        b_last_d  = b_last_q;
        b_valid_d = b_valid_q;
        rem_d     = rem_q;

        if (flush) begin
            state_d   = IDLE;
            b_valid_d = 1'b0;
        end else if (word_acc) begin
            word_d = w_data;
            if (n_take == 3'd0) begin
                state_d   = IDLE;
                b_valid_d = 1'b0;
            end else begin
                state_d   = SEND;
                b_valid_d = 1'b1;
                b_idx_d   = w_start;
                b_data_d  = pick_byte(w_data, w_start);
                b_last_d  = (n_take == 3'd1);
                rem_d     = n_take;
            end
        end else if ((state_q == SEND) && byte_hs) begin
            if (b_last_q) begin
                state_d   = IDLE;
                b_valid_d = 1'b0;
            end else begin
                b_idx_d  = b_idx_q + 2'd1;
                b_data_d = pick_byte(word_q, b_idx_q + 2'd1);
                rem_d    = rem_q - 3'd1;
                b_last_d = (rem_q == 3'd2);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            word_q    <= '0;
            b_data_q  <= '0;
            b_idx_q   <= '0;
            b_last_q  <= 1'b0;
            b_valid_q <= 1'b0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            b_data_q  <= b_data_d;
            b_idx_q   <= b_idx_d;
            b_last_q  <= b_last_d;
            b_valid_q <= b_valid_d;
            rem_q     <= rem_d;
        end
    end

    assign b_valid = b_valid_q;
    assign b_data  = b_data_q;
    assign b_idx   = b_idx_q;
    assign b_last  = b_last_q;

endmodule

// File: tb/tb_word_byte_serializer.sv
// Bench for word_byte_serializer: directed scenarios plus random traffic, all checked
// against a queue-of-pending-bytes reference model.
module tb_word_byte_serializer;

    logic        clk = 1'b0;
    logic        rst_n, flush, w_valid, b_ready;
    logic [31:0] w_data;
    logic [1:0]  w_start;
    logic [2:0]  w_len;
    logic        w_ready, b_valid, b_last;
    logic [7:0]  b_data;
    logic [1:0]  b_idx;

    always #5 clk = ~clk;

    word_byte_serializer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .w_valid (w_valid),
        .w_ready (w_ready),
        .w_data  (w_data),
        .w_start (w_start),
        .w_len   (w_len),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_data  (b_data),
        .b_idx   (b_idx),
        .b_last  (b_last)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] i;
    } byte_t;

    byte_t      cur[$];
    logic [7:0] seen[$];
    int         nvec = 0;
    int         nerr = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_seen();
        logic [63:0] r;
        r = '0;
        foreach (seen[j]) r = {r[55:0], seen[j]};
        return r;
    endfunction

    // One clock: drive inputs, check outputs against the model mid-cycle, advance the model.
    task automatic step(input logic fl, input logic wv, input logic [31:0] wd,
                        input logic [1:0] ws, input logic [2:0] wl, input logic br,
                        output logic acc);
        logic exp_wr;
        int   n;
        flush   = fl;
        w_valid = wv;
        w_data  = wd;
        w_start = ws;
        w_len   = wl;
        b_ready = br;
        @(negedge clk);
        exp_wr = !fl && (cur.size() == 0 || (br && cur.size() == 1));
        check_val("w_ready", w_ready, exp_wr);
        check_val("b_valid", b_valid, cur.size() > 0);
        if (cur.size() > 0) begin
            check_val("b_data", b_data, cur[0].d);
            check_val("b_idx", b_idx, cur[0].i);
            check_val("b_last", b_last, cur.size() == 1);
        end
        if (b_valid && br) seen.push_back(b_data);
        acc = wv && exp_wr;
        if (fl) begin
            cur.delete();
        end else begin
            if (cur.size() > 0 && br) void'(cur.pop_front());
            if (acc) begin
                n = (int'(wl) < 4 - int'(ws)) ? int'(wl) : 4 - int'(ws);
                for (int k = 0; k < n; k++)
                    cur.push_back('{d: 8'((wd >> (8 * (3 - (int'(ws) + k)))) & 32'hFF),
                                    i: 2'(int'(ws) + k)});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_steps(input int k);
        logic a;
        for (int j = 0; j < k; j++) step(1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b1, a);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_b_valid"}, b_valid, 1'b0);
        check_val({tag, "_b_data"}, b_data, 8'h00);
        check_val({tag, "_b_idx"}, b_idx, 2'd0);
        check_val({tag, "_b_last"}, b_last, 1'b0);
        check_val({tag, "_w_ready"}, w_ready, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic        a;
        logic [31:0] pend[$];
        int          hs_cnt;
        logic        bp_pat[7];

        rst_n = 1'b0; flush = 1'b0; w_valid = 1'b0; w_data = '0;
        w_start = '0; w_len = '0; b_ready = 1'b0;
        #2;
        check_reset_vals("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // full word, no backpressure
        seen.delete();
        step(1'b0, 1'b1, 32'hA1B2C3D4, 2'd0, 3'd4, 1'b1, a);
        idle_steps(5);
        check_val("full_count", seen.size(), 4);
        check_val("full_bytes", pack_seen(), 64'hA1B2C3D4);

        // clipping and offset
        seen.delete();
        step(1'b0, 1'b1, 32'hA1B2C3D4, 2'd2, 3'd4, 1'b1, a);
        idle_steps(3);
        check_val("clip_bytes", pack_seen(), 64'hC3D4);
        check_val("clip_count", seen.size(), 2);
        seen.delete();
        step(1'b0, 1'b1, 32'hA1B2C3D4, 2'd1, 3'd1, 1'b1, a);
        idle_steps(2);
        check_val("single_bytes", pack_seen(), 64'hB2);
        seen.delete();
        step(1'b0, 1'b1, 32'hA1B2C3D4, 2'd3, 3'd7, 1'b1, a);
        idle_steps(2);
        check_val("len7_bytes", pack_seen(), 64'hD4);

        // backpressure
        seen.delete();
        bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        step(1'b0, 1'b1, 32'hA1B2C3D4, 2'd0, 3'd4, 1'b0, a);
        foreach (bp_pat[j]) step(1'b0, 1'b0, 32'h0, 2'd0, 3'd0, bp_pat[j], a);
        idle_steps(1);
        check_val("bp_count", seen.size(), 4);
        check_val("bp_bytes", pack_seen(), 64'hA1B2C3D4);

        // back-to-back with w_valid held
        seen.delete();
        pend.push_back(32'h11223344);
        pend.push_back(32'h55667788);
        for (int c = 0; c < 12; c++) begin
            if (pend.size() > 0) begin
                step(1'b0, 1'b1, pend[0], 2'd0, 3'd4, 1'b1, a);
                if (a) void'(pend.pop_front());
            end else begin
                step(1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b1, a);
            end
        end
        check_val("b2b_bytes", pack_seen(), 64'h1122334455667788);

        // zero length, then next word on the following cycle
        seen.delete();
        step(1'b0, 1'b1, 32'hDEADBEEF, 2'd1, 3'd0, 1'b1, a);
        step(1'b0, 1'b1, 32'hCAFEF00D, 2'd1, 3'd2, 1'b1, a);
        idle_steps(3);
        check_val("zero_bytes", pack_seen(), 64'hFEF0);

        // flush at the second byte
        seen.delete();
        step(1'b0, 1'b1, 32'hA1B2C3D4, 2'd0, 3'd4, 1'b1, a);
        step(1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b1, a);
        step(1'b1, 1'b1, 32'h99887766, 2'd0, 3'd4, 1'b1, a);
        step(1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b1, a);
        step(1'b0, 1'b1, 32'h99887766, 2'd0, 3'd4, 1'b1, a);
        idle_steps(5);
        check_val("flush_bytes", pack_seen(), 64'hA1B299887766);

        // reset mid-word
        seen.delete();
        step(1'b0, 1'b1, 32'hA1B2C3D4, 2'd0, 3'd4, 1'b1, a);
        step(1'b0, 1'b0, 32'h0, 2'd0, 3'd0, 1'b1, a);
        rst_n = 1'b0;
        w_valid = 1'b1;
        #1;
        check_reset_vals("midrst");
        cur.delete();
        @(posedge clk);
        #1;
        check_reset_vals("holdrst");
        rst_n = 1'b1;
        idle_steps(1);
        step(1'b0, 1'b1, 32'h0BADF00D, 2'd2, 3'd2, 1'b1, a);
        idle_steps(3);
        check_val("rst_bytes", pack_seen(), 64'hA1F00D);

        // random traffic
        hs_cnt = 0;
        for (int c = 0; c < 500; c++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, $urandom,
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 7, a);
        end
        idle_steps(6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
